// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_ctrl
// Brief    : Round-robin arbitrated controller that sequences divider changes
//            (hold, apply, settle, ack) for a variable clock divider.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_ctrl #(
    parameter int NUM_REQ       = 4,
    parameter int MAX_DIVIDER   = 200,
    parameter int DEFAULT_DIV   = 1,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                       clk_in,
    input  logic                       rst_high_in,
    input  logic [NUM_REQ-1:0]         req_in,
    input  logic [8*NUM_REQ-1:0]       req_div_in,
    output logic [NUM_REQ-1:0]         ack_out,
    output logic [NUM_REQ-1:0]         err_out,
    output logic [7:0]                 div_out,
    output logic                       div_hold_out,
    output logic                       busy_out,
    output logic [$clog2(NUM_REQ)-1:0] owner_out
);

    localparam int            c_idx_w   = $clog2(NUM_REQ);
    localparam int            c_cnt_w   = $clog2(SETTLE_CYCLES + 1);
    localparam logic [8:0]    c_max_div = 9'(MAX_DIVIDER);
    localparam logic [7:0]    c_def_div = 8'(DEFAULT_DIV);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HOLD   = 3'd1,
        ST_APPLY  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_ACK    = 3'd4
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [7:0]           r_new_div, w_new_div_nxt;
    logic [7:0]           w_div_nxt, w_sel_div;
    logic [c_idx_w-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [c_idx_w-1:0]   w_sel_idx, w_owner_nxt;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
    logic                 w_any_req, w_hold_nxt, w_bad_div;
    logic [NUM_REQ-1:0]   w_ack_nxt, w_err_nxt;

    // Walk from the lowest to the highest priority offset so the last hit wins.
    always_comb begin
        w_sel_idx = '0;
        w_any_req = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_in[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_sel_idx = c_idx_w'((int'(r_rr_ptr) + k) % NUM_REQ);
                w_any_req = 1'b1;
            end
        end
    end

    assign w_sel_div = req_div_in[8*int'(w_sel_idx) +: 8];
    assign w_bad_div = (w_sel_div == 8'd0) || ({1'b0, w_sel_div} > c_max_div);

    always_comb begin
        w_state_nxt   = r_state;
        w_new_div_nxt = r_new_div;
        w_div_nxt     = div_out;
        w_hold_nxt    = 1'b0;
        w_ack_nxt     = '0;
        w_err_nxt     = '0;
        w_owner_nxt   = owner_out;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_cnt_nxt     = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_owner_nxt   = w_sel_idx;
                    w_new_div_nxt = w_sel_div;
                    w_rr_ptr_nxt  = (w_sel_idx == c_idx_w'(NUM_REQ - 1)) ? '0
                                                                         : w_sel_idx + 1'b1;
                    if (w_bad_div) begin
                        w_state_nxt          = ST_ACK;
                        w_ack_nxt[w_sel_idx] = 1'b1;
                        w_err_nxt[w_sel_idx] = 1'b1;
                    end else if (w_sel_div == div_out) begin
                        w_state_nxt          = ST_ACK;
                        w_ack_nxt[w_sel_idx] = 1'b1;
                    end else begin
                        w_state_nxt = ST_HOLD;
                        w_hold_nxt  = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                w_state_nxt = ST_APPLY;
                w_hold_nxt  = 1'b1;
                w_div_nxt   = r_new_div;
            end
            ST_APPLY: begin
                w_state_nxt = ST_SETTLE;
                w_cnt_nxt   = c_cnt_w'(SETTLE_CYCLES - 1);
            end
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt          = ST_ACK;
                    w_ack_nxt[owner_out] = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_high_in) begin
            r_state      <= ST_IDLE;
            r_new_div    <= c_def_div;
            r_rr_ptr     <= '0;
            r_cnt        <= '0;
            div_out      <= c_def_div;
            div_hold_out <= 1'b1;
            ack_out      <= '0;
            err_out      <= '0;
            busy_out     <= 1'b0;
            owner_out    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_new_div    <= w_new_div_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_cnt        <= w_cnt_nxt;
            div_out      <= w_div_nxt;
            div_hold_out <= w_hold_nxt;
            ack_out      <= w_ack_nxt;
            err_out      <= w_err_nxt;
            busy_out     <= (w_state_nxt != ST_IDLE);
            owner_out    <= w_owner_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_ctrl
// Brief    : Directed self-checking bench for clk_div_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_high_in;
    logic [3:0]  req_in;
    logic [31:0] req_div_in;
    logic [3:0]  ack_out, err_out;
    logic [7:0]  div_out;
    logic        div_hold_out, busy_out;
    logic [1:0]  owner_out;

    int   n_checks = 0;
    int   n_errors = 0;
    logic hold_seen = 1'b0;
    logic ack_seen  = 1'b0;

    clk_div_ctrl #(
        .NUM_REQ       (4),
        .MAX_DIVIDER   (200),
        .DEFAULT_DIV   (1),
        .SETTLE_CYCLES (16)
    ) u_dut (
        .clk_in       (clk_in),
        .rst_high_in  (rst_high_in),
        .req_in       (req_in),
        .req_div_in   (req_div_in),
        .ack_out      (ack_out),
        .err_out      (err_out),
        .div_out      (div_out),
        .div_hold_out (div_hold_out),
        .busy_out     (busy_out),
        .owner_out    (owner_out)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (div_hold_out) hold_seen = 1'b1;
        if (ack_out != 4'b0) ack_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    // Steps until an ack is seen or the budget runs out; a=0 on timeout.
    task automatic wait_ack(input int max, output int n, output logic [3:0] a,
                            output logic [3:0] e);
        bit done = 0;
        n = 0; a = '0; e = '0;
        while (!done && n < max) begin
            step();
            n++;
            if (ack_out != 4'b0) begin
                a = ack_out;
                e = err_out;
                done = 1;
            end
        end
    endtask

    task automatic do_reset();
        rst_high_in = 1'b1;
        req_in      = '0;
        step();
        step();
        rst_high_in = 1'b0;
        step();
    endtask

    int         lat;
    logic [3:0] a, e;
    logic [7:0] exp_div [4];

    initial begin
        rst_high_in = 1'b1;
        req_in      = '0;
        req_div_in  = '0;
        step();
        step();
        chk("rst_div", div_out, 8'd1);
        chk("rst_hold", div_hold_out, 1'b1);
        chk("rst_busy", busy_out, 1'b0);
        chk("rst_ack", ack_out, 4'b0);
        chk("rst_err", err_out, 4'b0);
        chk("rst_owner", owner_out, 2'd0);
        rst_high_in = 1'b0;
        step();
        chk("post_rst_hold", div_hold_out, 1'b0);

        // Single legal change from requester 0.
        req_div_in[7:0] = 8'd10;
        req_in          = 4'b0001;
        step();
        chk("t1_hold", div_hold_out, 1'b1);
        chk("t1_div", div_out, 8'd1);
        chk("t1_busy", busy_out, 1'b1);
        step();
        chk("t2_hold", div_hold_out, 1'b1);
        chk("t2_div", div_out, 8'd10);
        step();
        chk("t3_hold", div_hold_out, 1'b0);
        repeat (15) step();
        chk("t18_ack", ack_out, 4'b0);
        step();
        chk("t19_ack", ack_out, 4'b0001);
        chk("t19_err", err_out, 4'b0);
        req_in = '0;
        step();
        chk("t20_ack", ack_out, 4'b0);
        chk("t20_busy", busy_out, 1'b0);

        // All four requesting continuously: round-robin order from reset.
        do_reset();
        exp_div = '{8'd20, 8'd30, 8'd40, 8'd50};
        req_div_in = {8'd50, 8'd40, 8'd30, 8'd20};
        req_in     = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(40, lat, a, e);
            chk($sformatf("rr%0d_ack", k), a, 4'b0001 << (k % 4));
            chk($sformatf("rr%0d_err", k), e, 4'b0);
            chk($sformatf("rr%0d_lat", k), lat, (k == 0) ? 19 : 20);
            chk($sformatf("rr%0d_div", k), div_out, exp_div[k % 4]);
        end
        req_in = '0;
        step();

        // Rejects: div 0 from requester 1, div 201 from requester 2.
        hold_seen  = 1'b0;
        req_div_in = {8'd0, 8'd201, 8'd0, 8'd0};
        req_in     = 4'b0010;
        wait_ack(40, lat, a, e);
        chk("rej0_ack", a, 4'b0010);
        chk("rej0_err", e, 4'b0010);
        chk("rej0_lat", lat, 1);
        req_in = '0;
        step();
        req_in = 4'b0100;
        wait_ack(40, lat, a, e);
        chk("rej201_ack", a, 4'b0100);
        chk("rej201_err", e, 4'b0100);
        chk("rej201_lat", lat, 1);
        req_in = '0;
        step();
        chk("rej_div", div_out, 8'd20);
        chk("rej_hold_seen", hold_seen, 1'b0);

        // Boundary value MAX_DIVIDER is legal.
        req_div_in = {8'd200, 24'd0};
        req_in     = 4'b1000;
        wait_ack(40, lat, a, e);
        chk("max_ack", a, 4'b1000);
        chk("max_err", e, 4'b0);
        chk("max_lat", lat, 19);
        chk("max_div", div_out, 8'd200);
        req_in = '0;
        step();

        // Same value as current divider: quick ack, no hold.
        hold_seen  = 1'b0;
        req_div_in = {24'd0, 8'd200};
        req_in     = 4'b0001;
        wait_ack(40, lat, a, e);
        chk("same_ack", a, 4'b0001);
        chk("same_err", e, 4'b0);
        chk("same_lat", lat, 1);
        req_in = '0;
        step();
        chk("same_hold_seen", hold_seen, 1'b0);

        // Reset during SETTLE aborts the sequence.
        req_div_in = {24'd0, 8'd77};
        req_in     = 4'b0001;
        repeat (5) step();
        chk("abort_pre_div", div_out, 8'd77);
        chk("abort_pre_busy", busy_out, 1'b1);
        rst_high_in = 1'b1;
        req_in      = '0;
        step();
        chk("abort_div", div_out, 8'd1);
        chk("abort_hold", div_hold_out, 1'b1);
        chk("abort_busy", busy_out, 1'b0);
        chk("abort_ack", ack_out, 4'b0);
        rst_high_in = 1'b0;
        ack_seen    = 1'b0;
        step();
        chk("abort_hold_rel", div_hold_out, 1'b0);
        repeat (20) step();
        chk("abort_no_ack", ack_seen, 1'b0);
        chk("abort_idle_busy", busy_out, 1'b0);

        // Requester 2 drops its request during HOLD; still acked at t+19.
        req_div_in = {8'd0, 8'd33, 16'd0};
        req_in     = 4'b0100;
        step();
        chk("drop_hold", div_hold_out, 1'b1);
        chk("drop_owner", owner_out, 2'd2);
        req_in = '0;
        wait_ack(40, lat, a, e);
        chk("drop_ack", a, 4'b0100);
        chk("drop_err", e, 4'b0);
        chk("drop_lat", lat, 18);
        chk("drop_div", div_out, 8'd33);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
